// File: rtl/fmq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fmq_pkg
//  Description : Shared definitions for the host command framer and its
//                consumers: opcode values, command field widths and the
//                framer state encoding.
//  Contents    : OP_* opcodes, CMD_ADDR_W / CMD_DATA_W, state_t,
//                is_header() helper.
//  Revision    : 1.0  initial release
// ============================================================================
package fmq_pkg;

  localparam logic [1:0] OP_SET_OFFSET = 2'b00;
  localparam logic [1:0] OP_RELOAD     = 2'b01;
  localparam logic [1:0] OP_QUERY      = 2'b10;
  localparam logic [1:0] OP_DAC        = 2'b11;

  localparam int CMD_ADDR_W = 7;
  localparam int CMD_DATA_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_B1     = 3'd1,
    ST_B2     = 3'd2,
    ST_DECODE = 3'd3,
    ST_ISSUE  = 3'd4,
    ST_REPLY  = 3'd5
  } state_t;

  // Header bytes are the only bytes with the top bit set.
  function automatic logic is_header(input logic [7:0] b);
    return b[7];
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_framer_tx_hold_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tx_hold_reg
//  Description : One-entry stream holding register feeding the UART
//                transmitter. Two writers share it: the echo path and the
//                query-reply path; echo wins if both load together.
//                Writers only load when the entry is empty or draining.
//  Ports       : clk, rst (async, active-low)
//                i_echo_valid/i_echo_data  echo write
//                i_rep_valid/i_rep_data    reply write
//                o_tdata/o_tvalid/i_tready stream to transmitter
//                o_tvalid_nxt              occupancy after the coming edge
//  Revision    : 1.0  initial release
// ============================================================================
module tx_hold_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_echo_valid,
  input  logic [7:0] i_echo_data,
  input  logic       i_rep_valid,
  input  logic [7:0] i_rep_data,
  output logic [7:0] o_tdata,
  output logic       o_tvalid,
  input  logic       i_tready,
  output logic       o_tvalid_nxt
);

  logic [7:0] r_tdata;
  logic       r_tvalid;
  logic       w_load;

  assign w_load       = i_echo_valid | i_rep_valid;
  // Exported so the parent can register its rx-ready from the same value.
  assign o_tvalid_nxt = w_load | (r_tvalid & ~i_tready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tdata  <= 8'h00;
      r_tvalid <= 1'b0;
    end else begin
      r_tvalid <= o_tvalid_nxt;
      if (w_load) begin
        r_tdata <= i_echo_valid ? i_echo_data : i_rep_data;
      end
    end
  end

  assign o_tdata  = r_tdata;
  assign o_tvalid = r_tvalid;

endmodule
`default_nettype wire

// File: rtl/uart_cmd_framer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_framer
//  Description : Frames 3-byte host commands from the UART rx stream,
//                echoes accepted bytes on the tx stream, answers the
//                output-count query locally and presents every other
//                command on a valid/ready port. Inter-byte timeout drops
//                partial frames; a saturating counter tallies errors.
//  Ports       : clk, rst (async, active-low)
//                s_rx_*      byte stream from the UART receiver
//                m_tx_*      byte stream to the UART transmitter
//                cmd_*       decoded command (op, addr, data)
//                frame_err_cnt  saturating error count
//                busy        framer is not idle
//  Revision    : 1.0  initial release
// ============================================================================
module uart_cmd_framer
  import fmq_pkg::*;
#(
  parameter int unsigned OUTPUTS        = 88,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned ECHO           = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_rx_tdata,
  input  logic                  s_rx_tvalid,
  output logic                  s_rx_tready,
  output logic [7:0]            m_tx_tdata,
  output logic                  m_tx_tvalid,
  input  logic                  m_tx_tready,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [1:0]            cmd_op,
  output logic [CMD_ADDR_W-1:0] cmd_addr,
  output logic [CMD_DATA_W-1:0] cmd_data,
  output logic [7:0]            frame_err_cnt,
  output logic                  busy
);

  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [6:0]            r_b0;
  logic [6:0]            r_b1;
  logic [6:0]            r_b2;
  logic [TO_W-1:0]       r_to_cnt;
  logic [7:0]            r_err;
  logic                  r_rx_ready;
  logic                  r_busy;
  logic                  r_cmd_valid;
  logic [1:0]            r_cmd_op;
  logic [CMD_ADDR_W-1:0] r_cmd_addr;
  logic [CMD_DATA_W-1:0] r_cmd_data;

  logic                  w_rx_hs;
  logic                  w_cmd_hs;
  logic                  w_hdr;
  logic                  w_in_frame;
  logic                  w_timeout;
  logic                  w_err;
  logic                  w_store_b0;
  logic                  w_store_b1;
  logic                  w_store_b2;
  logic                  w_issue;
  logic                  w_reply_load;
  logic                  w_echo_load;
  logic                  w_tx_valid_nxt;
  logic                  w_rx_state_ok;
  logic [1:0]            w_dec_op;
  logic [CMD_ADDR_W-1:0] w_dec_addr;
  logic [CMD_DATA_W-1:0] w_dec_data;
  logic                  w_addr_bad;

  assign w_rx_hs    = s_rx_tvalid & r_rx_ready;
  assign w_cmd_hs   = r_cmd_valid & cmd_ready;
  assign w_hdr      = is_header(s_rx_tdata);
  assign w_in_frame = (r_state == ST_B1) || (r_state == ST_B2);
  // A byte arriving on the expiry cycle takes precedence in the FSM below.
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && w_in_frame && (r_to_cnt == C_TO_LAST);

  assign w_dec_op   = r_b0[6:5];
  assign w_dec_addr = {r_b0[4:0], r_b1[6:5]};
  assign w_dec_data = {r_b1[4:0], r_b2[6:0]};
  assign w_addr_bad = (w_dec_op == OP_SET_OFFSET) && (32'(w_dec_addr) >= OUTPUTS);

  always_comb begin
    w_state_nxt  = r_state;
    w_err        = 1'b0;
    w_store_b0   = 1'b0;
    w_store_b1   = 1'b0;
    w_store_b2   = 1'b0;
    w_issue      = 1'b0;
    w_reply_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rx_hs) begin
          if (w_hdr) begin
            w_store_b0  = 1'b1;
            w_state_nxt = ST_B1;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      ST_B1, ST_B2: begin
        if (w_rx_hs) begin
          if (w_hdr) begin
            // Unexpected header restarts the frame with this byte as b0.
            w_err       = 1'b1;
            w_store_b0  = 1'b1;
            w_state_nxt = ST_B1;
          end else if (r_state == ST_B1) begin
            w_store_b1  = 1'b1;
            w_state_nxt = ST_B2;
          end else begin
            w_store_b2  = 1'b1;
            w_state_nxt = ST_DECODE;
          end
        end else if (w_timeout) begin
          w_err       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (w_dec_op == OP_QUERY) begin
          w_state_nxt = ST_REPLY;
        end else if (w_addr_bad) begin
          w_err       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_issue     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (w_cmd_hs) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REPLY: begin
        if (!m_tx_tvalid) begin
          w_reply_load = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_echo_load   = (ECHO != 0) && w_rx_hs;
  assign w_rx_state_ok = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_B1) ||
                         (w_state_nxt == ST_B2);

  tx_hold_reg u_tx_hold (
    .clk          (clk),
    .rst          (rst),
    .i_echo_valid (w_echo_load),
    .i_echo_data  (s_rx_tdata),
    .i_rep_valid  (w_reply_load),
    .i_rep_data   (8'(OUTPUTS)),
    .o_tdata      (m_tx_tdata),
    .o_tvalid     (m_tx_tvalid),
    .i_tready     (m_tx_tready),
    .o_tvalid_nxt (w_tx_valid_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_b0        <= 7'd0;
      r_b1        <= 7'd0;
      r_b2        <= 7'd0;
      r_to_cnt    <= '0;
      r_err       <= 8'd0;
      r_rx_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_op    <= 2'd0;
      r_cmd_addr  <= '0;
      r_cmd_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      // Ready is registered from next-cycle state and tx occupancy, so an
      // echo always drains before the following rx byte is taken.
      r_rx_ready <= w_rx_state_ok && ((ECHO == 0) || !w_tx_valid_nxt);

      if (w_store_b0) r_b0 <= s_rx_tdata[6:0];
      if (w_store_b1) r_b1 <= s_rx_tdata[6:0];
      if (w_store_b2) r_b2 <= s_rx_tdata[6:0];

      if ((TIMEOUT_CYCLES == 0) || w_rx_hs || !w_in_frame) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      if (w_err && (r_err != 8'hFF)) begin
        r_err <= r_err + 8'd1;
      end

      if (w_issue) begin
        r_cmd_valid <= 1'b1;
        r_cmd_op    <= w_dec_op;
        r_cmd_addr  <= w_dec_addr;
        r_cmd_data  <= w_dec_data;
      end else if (w_cmd_hs) begin
        r_cmd_valid <= 1'b0;
      end
    end
  end

  assign s_rx_tready   = r_rx_ready;
  assign cmd_valid     = r_cmd_valid;
  assign cmd_op        = r_cmd_op;
  assign cmd_addr      = r_cmd_addr;
  assign cmd_data      = r_cmd_data;
  assign frame_err_cnt = r_err;
  assign busy          = r_busy;

endmodule
`default_nettype wire
